// File: rtl/stream_bit_reorder_if.sv
// stream_bit_reorder_if: valid/ready sample stream into and out of the bit-reversal reorder buffer
// Ports (master = producer/consumer side, slave = reorder block):
//   in_valid/in_ready/in_data/in_mode : input sample stream, in_mode sampled with a frame's first sample
//   out_valid/out_ready/out_data/out_last : reordered output stream, out_last marks a frame's final sample
interface stream_bit_reorder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_bit_reorder.sv
// stream_bit_reorder: ping-pong frame buffer emitting N = 2^LOG2N samples in bit-reversed or natural order
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   s     : stream_bit_reorder_if slave (input stream in, reordered stream out)
module stream_bit_reorder #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 3
) (
    input logic               clk,
    input logic               rst_n,
    stream_bit_reorder_if.slave s
);
    localparam int N = 1 << LOG2N;
    logic [WIDTH-1:0] mem_q [2][N];
    logic [1:0]       full_q, full_d, mode_q, mode_d;
    logic             wr_bank_q, rd_bank_q;
    logic [LOG2N-1:0] wr_cnt_q, rd_cnt_q, rev, rd_addr;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             wr_fire, wr_end, rd_issue, rd_end;
    // writer only ever fills a non-full bank, reader only drains a full one, so they never collide
    assign s.in_ready = !full_q[wr_bank_q];
    assign wr_fire    = s.in_valid && !full_q[wr_bank_q];
    assign wr_end     = wr_fire && (&wr_cnt_q);
    assign rd_issue   = full_q[rd_bank_q] && (!out_valid_q || s.out_ready);
    assign rd_end     = rd_issue && (&rd_cnt_q);
    always_comb begin
        rev = '0;
        for (int k = 0; k < LOG2N; k++) rev[k] = rd_cnt_q[LOG2N-1-k];
    end
    assign rd_addr = mode_q[rd_bank_q] ? rd_cnt_q : rev;
    always_comb begin
        full_d = full_q;
        mode_d = mode_q;
        if (wr_fire && wr_cnt_q == '0) mode_d[wr_bank_q] = s.in_mode;
        if (wr_end) full_d[wr_bank_q] = 1'b1;
        if (rd_end) full_d[rd_bank_q] = 1'b0;
        // output register holds while stalled and clears once taken with nothing new to issue
        out_valid_d = rd_issue || (out_valid_q && !s.out_ready);
        out_last_d  = rd_issue ? (&rd_cnt_q) : (out_last_q && !s.out_ready);
        out_data_d  = rd_issue ? mem_q[rd_bank_q][rd_addr] : out_data_q;
    end
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_bank_q][wr_cnt_q] <= s.in_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            mode_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            full_q      <= full_d;
            mode_q      <= mode_d;
            wr_bank_q   <= wr_bank_q ^ wr_end;
            rd_bank_q   <= rd_bank_q ^ rd_end;
            wr_cnt_q    <= wr_cnt_q + LOG2N'(wr_fire);
            rd_cnt_q    <= rd_cnt_q + LOG2N'(rd_issue);
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end
    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign s.out_data  = out_data_q;
endmodule
